// File: rtl/miner_msg_uart_tx.sv
// rtl/miner_msg_uart_tx.sv - message-to-UART serializer for the miner core (optional CRLF trailer via MSG_TX_CRLF_EN)
module miner_msg_uart_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int MSG_BYTES    = 9
) (
  input  logic          CLOCK_50,
  input  logic          reset,
  input  logic [1023:0] msg,
  input  logic          delivery_msg,
  output logic          tx,
  output logic          busy,
  output logic [7:0]    drop_count
);

`ifdef MSG_TX_CRLF_EN
  localparam int NUM_BYTES = MSG_BYTES + 2;
`else
  localparam int NUM_BYTES = MSG_BYTES;
`endif
  localparam int              BW        = $clog2(CLKS_PER_BIT);
  localparam int              MW        = 8 * MSG_BYTES;
  localparam logic [BW-1:0]   BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [7:0]      LAST_IDX  = 8'(NUM_BYTES - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_START,
    ST_DATA,
    ST_STOP
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic            s1;
  logic            s2;
  logic            s3;
  logic            req;
  logic            baud_end;
  logic [BW-1:0]   baud_cnt;
  logic [2:0]      bit_idx;
  logic [7:0]      byte_cnt;
  logic [7:0]      cur_byte;
  logic [MW-1:0]   shift_buf;

  // Only the low MSG_BYTES bytes of msg are ever transmitted.
  generate
    if (MW < 1024) begin : g_msg_hi
      logic unused_msg_hi;
      assign unused_msg_hi = ^msg[1023:MW];
    end
  endgenerate

  assign req      = s2 & ~s3;
  assign baud_end = (baud_cnt == BAUD_LAST);

  // Two-flop synchronizer for the CLOCK_3-domain request plus a history flop for edge detect.
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= delivery_msg;
      s2 <= s1;
      s3 <= s2;
    end
  end

  // FSM state register.
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and line outputs; tx is decoded from state so reset forces it high at once.
  always_comb begin
    state_nxt = state;
    tx        = 1'b1;
    busy      = (state != ST_IDLE);
    case (state)
      ST_IDLE: begin
        if (req) state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        state_nxt = ST_START;
      end
      ST_START: begin
        tx = 1'b0;
        if (baud_end) state_nxt = ST_DATA;
      end
      ST_DATA: begin
        tx = cur_byte[bit_idx];
        if (baud_end && (bit_idx == 3'd7)) state_nxt = ST_STOP;
      end
      ST_STOP: begin
        if (baud_end) state_nxt = (byte_cnt == LAST_IDX) ? ST_IDLE : ST_LOAD;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Baud timing, bit/byte indices and the captured message buffer.
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      baud_cnt  <= '0;
      bit_idx   <= 3'd0;
      byte_cnt  <= 8'd0;
      cur_byte  <= 8'd0;
      shift_buf <= '0;
    end else begin
      if ((state == ST_START) || (state == ST_DATA) || (state == ST_STOP)) begin
        baud_cnt <= baud_end ? '0 : baud_cnt + 1'b1;
      end else begin
        baud_cnt <= '0;
      end

      case (state)
        ST_IDLE: begin
          if (req) begin
            shift_buf <= msg[MW-1:0];
            byte_cnt  <= 8'd0;
          end
        end
        ST_LOAD: begin
          bit_idx   <= 3'd0;
          // Buffer shifts left so the next byte in MS-first order is always on top.
          shift_buf <= shift_buf << 8;
`ifdef MSG_TX_CRLF_EN
          if (byte_cnt == 8'(MSG_BYTES)) begin
            cur_byte <= 8'h0D;
          end else if (byte_cnt == 8'(MSG_BYTES + 1)) begin
            cur_byte <= 8'h0A;
          end else begin
            cur_byte <= shift_buf[MW-1 -: 8];
          end
`else
          cur_byte  <= shift_buf[MW-1 -: 8];
`endif
        end
        ST_DATA: begin
          if (baud_end) bit_idx <= bit_idx + 3'd1;
        end
        ST_STOP: begin
          if (baud_end && (byte_cnt != LAST_IDX)) byte_cnt <= byte_cnt + 8'd1;
        end
        default: begin
        end
      endcase
    end
  end

  // Requests arriving while busy (including the final STOP cycle) are dropped and counted.
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      drop_count <= 8'd0;
    end else if (req && busy && (drop_count != 8'hFF)) begin
      drop_count <= drop_count + 8'd1;
    end
  end

endmodule
